// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs, one grant per cycle onto a registered CDB,
// mispredict flush of younger entries. Define CDB_AGE_PRIORITY_EN for oldest-first arbitration.
module cdb_arbiter #(
   parameter int NUM_FU     = 3,
   parameter int PREG_WIDTH = 7,
   parameter int ROB_WIDTH  = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_FU-1:0]            i_req_valid,
   output logic [NUM_FU-1:0]            o_req_ready,
   input  logic [NUM_FU*PREG_WIDTH-1:0] i_req_prd,
   input  logic [NUM_FU*ROB_WIDTH-1:0]  i_req_rob_tag,
   input  logic [NUM_FU*32-1:0]         i_req_data,
   input  logic [ROB_WIDTH-1:0]         i_rob_head,
   input  logic                         branch_mispredict,
   input  logic [ROB_WIDTH-1:0]         mispredict_rob_tag,
   output logic                         o_cdb_valid,
   output logic [PREG_WIDTH-1:0]        o_cdb_prd,
   output logic [ROB_WIDTH-1:0]         o_cdb_rob_tag,
   output logic [31:0]                  o_cdb_data,
   output logic [$clog2(NUM_FU)-1:0]    o_cdb_src
);
   localparam int SRC_W = $clog2(NUM_FU);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Younger than the branch: nonzero forward distance in the lower half of the tag ring.
   function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                       input logic [ROB_WIDTH-1:0] br);
      logic [ROB_WIDTH-1:0] d;
      d = tag - br;
      return (d != {ROB_WIDTH{1'b0}}) && (d[ROB_WIDTH-1] == 1'b0);
   endfunction

   logic                  ent_valid_r [NUM_FU][FIFO_DEPTH];
   logic [PREG_WIDTH-1:0] ent_prd_r   [NUM_FU][FIFO_DEPTH];
   logic [ROB_WIDTH-1:0]  ent_tag_r   [NUM_FU][FIFO_DEPTH];
   logic [31:0]           ent_data_r  [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r    [NUM_FU];
   logic [PTR_W-1:0]      wr_ptr_r    [NUM_FU];
   logic [CNT_W-1:0]      count_r     [NUM_FU];

   logic [NUM_FU-1:0]     push_s;
   logic [NUM_FU-1:0]     pop_s;
   logic [NUM_FU-1:0]     cand_s;
   logic [NUM_FU-1:0]     dead_s;
   logic [NUM_FU-1:0]     grant_s;
   logic                  win_valid_s;
   logic [SRC_W-1:0]      win_s;
   logic [PREG_WIDTH-1:0] sel_prd_s;
   logic [ROB_WIDTH-1:0]  sel_tag_s;
   logic [31:0]           sel_data_s;

   // Per-unit readiness, head classification and accepted pushes.
   always_comb begin
      o_req_ready = {NUM_FU{1'b0}};
      cand_s      = {NUM_FU{1'b0}};
      dead_s      = {NUM_FU{1'b0}};
      push_s      = {NUM_FU{1'b0}};
      for (int k = 0; k < NUM_FU; k++) begin
         o_req_ready[k] = (count_r[k] < CNT_W'(FIFO_DEPTH));
         if (count_r[k] != {CNT_W{1'b0}}) begin
            // a head being flushed this cycle is already treated as dead
            if (ent_valid_r[k][rd_ptr_r[k]] &&
                !(branch_mispredict && is_younger(ent_tag_r[k][rd_ptr_r[k]], mispredict_rob_tag))) begin
               cand_s[k] = 1'b1;
            end else begin
               dead_s[k] = 1'b1;
            end
         end else begin
            cand_s[k] = 1'b0;
         end
         push_s[k] = i_req_valid[k] && o_req_ready[k] &&
                     !(branch_mispredict &&
                       is_younger(i_req_rob_tag[k*ROB_WIDTH +: ROB_WIDTH], mispredict_rob_tag));
      end
   end

`ifdef CDB_AGE_PRIORITY_EN
   logic [ROB_WIDTH-1:0] age_s;
   logic [ROB_WIDTH-1:0] best_age_s;

   // Oldest-first: smallest distance from the ROB head, ties to the lowest index.
   always_comb begin
      win_valid_s = 1'b0;
      win_s       = {SRC_W{1'b0}};
      best_age_s  = {ROB_WIDTH{1'b1}};
      age_s       = {ROB_WIDTH{1'b0}};
      for (int k = 0; k < NUM_FU; k++) begin
         age_s = ent_tag_r[k][rd_ptr_r[k]] - i_rob_head;
         if (cand_s[k] && (!win_valid_s || (age_s < best_age_s))) begin
            win_valid_s = 1'b1;
            win_s       = SRC_W'(k);
            best_age_s  = age_s;
         end else begin
            best_age_s  = best_age_s;
         end
      end
   end
`else
   logic [SRC_W-1:0] rr_ptr_r;
   logic             unused_rob_head_s;

   assign unused_rob_head_s = ^i_rob_head;

   // Round-robin: first candidate at or after rr_ptr.
   always_comb begin
      int idx;
      win_valid_s = 1'b0;
      win_s       = {SRC_W{1'b0}};
      idx         = 0;
      for (int i = 0; i < NUM_FU; i++) begin
         idx = int'(rr_ptr_r) + i;
         if (idx >= NUM_FU) begin
            idx = idx - NUM_FU;
         end else begin
            idx = idx;
         end
         if (!win_valid_s && cand_s[idx]) begin
            win_valid_s = 1'b1;
            win_s       = SRC_W'(idx);
         end else begin
            win_valid_s = win_valid_s;
         end
      end
   end

   // Pointer moves past the winner only on a real grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= {SRC_W{1'b0}};
      end else if (win_valid_s) begin
         rr_ptr_r <= (win_s == SRC_W'(NUM_FU - 1)) ? {SRC_W{1'b0}} : win_s + SRC_W'(1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`endif

   // One-hot grant, winner head fields and pop requests.
   always_comb begin
      grant_s    = {NUM_FU{1'b0}};
      sel_prd_s  = {PREG_WIDTH{1'b0}};
      sel_tag_s  = {ROB_WIDTH{1'b0}};
      sel_data_s = 32'h0000_0000;
      for (int k = 0; k < NUM_FU; k++) begin
         if (win_valid_s && (win_s == SRC_W'(k))) begin
            grant_s[k] = 1'b1;
            sel_prd_s  = ent_prd_r[k][rd_ptr_r[k]];
            sel_tag_s  = ent_tag_r[k][rd_ptr_r[k]];
            sel_data_s = ent_data_r[k][rd_ptr_r[k]];
         end else begin
            grant_s[k] = 1'b0;
         end
      end
      pop_s = grant_s | dead_s;
   end

   // FIFO storage: flush kill, pop, push (push writes an empty slot, so order is safe).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_FU; k++) begin
            rd_ptr_r[k] <= {PTR_W{1'b0}};
            wr_ptr_r[k] <= {PTR_W{1'b0}};
            count_r[k]  <= {CNT_W{1'b0}};
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               ent_valid_r[k][e] <= 1'b0;
               ent_prd_r[k][e]   <= {PREG_WIDTH{1'b0}};
               ent_tag_r[k][e]   <= {ROB_WIDTH{1'b0}};
               ent_data_r[k][e]  <= 32'h0000_0000;
            end
         end
      end else begin
         for (int k = 0; k < NUM_FU; k++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               if (branch_mispredict && is_younger(ent_tag_r[k][e], mispredict_rob_tag)) begin
                  ent_valid_r[k][e] <= 1'b0;
               end else begin
                  ent_valid_r[k][e] <= ent_valid_r[k][e];
               end
            end
            if (pop_s[k]) begin
               ent_valid_r[k][rd_ptr_r[k]] <= 1'b0;
               rd_ptr_r[k] <= rd_ptr_r[k] + PTR_W'(1);
            end else begin
               rd_ptr_r[k] <= rd_ptr_r[k];
            end
            if (push_s[k]) begin
               ent_valid_r[k][wr_ptr_r[k]] <= 1'b1;
               ent_prd_r[k][wr_ptr_r[k]]   <= i_req_prd[k*PREG_WIDTH +: PREG_WIDTH];
               ent_tag_r[k][wr_ptr_r[k]]   <= i_req_rob_tag[k*ROB_WIDTH +: ROB_WIDTH];
               ent_data_r[k][wr_ptr_r[k]]  <= i_req_data[k*32 +: 32];
               wr_ptr_r[k] <= wr_ptr_r[k] + PTR_W'(1);
            end else begin
               wr_ptr_r[k] <= wr_ptr_r[k];
            end
            count_r[k] <= count_r[k] + CNT_W'(push_s[k]) - CNT_W'(pop_s[k]);
         end
      end
   end

   // Registered CDB broadcast; fields hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_cdb_valid   <= 1'b0;
         o_cdb_prd     <= {PREG_WIDTH{1'b0}};
         o_cdb_rob_tag <= {ROB_WIDTH{1'b0}};
         o_cdb_data    <= 32'h0000_0000;
         o_cdb_src     <= {SRC_W{1'b0}};
      end else if (win_valid_s) begin
         o_cdb_valid   <= 1'b1;
         o_cdb_prd     <= sel_prd_s;
         o_cdb_rob_tag <= sel_tag_s;
         o_cdb_data    <= sel_data_s;
         o_cdb_src     <= win_s;
      end else begin
         o_cdb_valid   <= 1'b0;
         o_cdb_prd     <= o_cdb_prd;
         o_cdb_rob_tag <= o_cdb_rob_tag;
         o_cdb_data    <= o_cdb_data;
         o_cdb_src     <= o_cdb_src;
      end
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among NUM_FU execution units (ALU, branch, load/store) that complete out of order. Each unit pushes results into a private small FIFO, and each cycle the arbiter grants one valid FIFO head onto a registered CDB. That CDB drives reservation-station wakeup, the physical register file write port and ROB completion. On a branch mispredict it discards buffered results younger than the mispredicting instruction.

## Interface
Parameters:
- NUM_FU, 3, number of requesting execution units (≥2)
- PREG_WIDTH, 7, physical register tag width
- ROB_WIDTH, 4, ROB tag width
- FIFO_DEPTH, 2, entries per requester FIFO (power of two, ≥2)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req_valid  in  NUM_FU  per-unit result valid
- o_req_ready  out  NUM_FU  per-unit FIFO can accept
- i_req_prd  in  NUM_FU*PREG_WIDTH  destination preg, unit k at [k*PREG_WIDTH +: PREG_WIDTH]
- i_req_rob_tag  in  NUM_FU*ROB_WIDTH  ROB tag per unit
- i_req_data  in  NUM_FU*32  result value per unit
- i_rob_head  in  ROB_WIDTH  oldest in-flight ROB tag (age reference)
- branch_mispredict  in  1  flush pulse
- mispredict_rob_tag  in  ROB_WIDTH  tag of mispredicting branch
- o_cdb_valid  out  1  broadcast valid
- o_cdb_prd  out  PREG_WIDTH  broadcast preg
- o_cdb_rob_tag  out  ROB_WIDTH  broadcast ROB tag
- o_cdb_data  out  32  broadcast value
- o_cdb_src  out  $clog2(NUM_FU)  index of granted unit

## Operation
- Enqueue: unit k pushes when i_req_valid[k] && o_req_ready[k]. o_req_ready[k] = (count[k] < FIFO_DEPTH), derived from registered state only. It is never combinationally dependent on same-cycle grants.
- Candidate: a FIFO whose head entry is valid.
- Grant: one candidate per cycle. The winner's head is popped and its fields are registered onto the CDB outputs.
- Default policy is round-robin. The search starts at rr_ptr, and after a grant to unit g, rr_ptr <= (g+1) mod NUM_FU. rr_ptr is unchanged when nothing is granted.
- Age/younger test: age(t) = t − i_rob_head, computed mod 2^ROB_WIDTH. Tag t is younger than the branch when d = t − mispredict_rob_tag (mod 2^ROB_WIDTH) satisfies d ≠ 0 && d < 2^(ROB_WIDTH−1).
- Flush when branch_mispredict is high:
  - Every buffered entry that is younger than the branch is invalidated.
  - A same-cycle enqueue of a younger tag is dropped.
  - Arbitration that cycle considers only surviving entries, so no younger result reaches the CDB on the next cycle.
  - The branch's own tag (d = 0) and older tags survive.
- Invalidated heads: an invalidated head is popped silently, at most one per FIFO per cycle. A silent pop does not count as a grant and does not move rr_ptr.
- A FIFO may be pushed and popped in the same cycle. Its count is then unchanged. When full it still reports not-ready that cycle.

## Timing
- Reset values:
  - o_cdb_valid = 0, and o_cdb_prd, o_cdb_rob_tag, o_cdb_data, o_cdb_src are all 0.
  - All FIFOs are empty, with all entry valid bits 0.
  - o_req_ready is all 1.
  - rr_ptr = 0.
- Latency: a result accepted at edge t into an empty FIFO becomes a candidate in cycle t+1. If granted, it is visible on the CDB in cycle t+2.
  - Equivalently, push cycle N gives broadcast at earliest cycle N+2.
- o_cdb_valid is high for exactly one cycle per granted entry. Each entry is broadcast exactly once.
- Reset asserted mid-operation discards all entries, and the outputs take their reset values at the next edge.
- A branch_mispredict that coincides with reset is ignored, because reset wins.

## Configuration
- CDB_AGE_PRIORITY_EN defined: round-robin is replaced by oldest-first. The candidate with the smallest age(rob_tag) wins, and ties are broken by the lowest unit index. rr_ptr is removed.
- Not defined: the round-robin policy described above.

## Test plan
- Reset, then idle: o_cdb_valid = 0, o_req_ready = 3'b111, all CDB fields 0 for 10 cycles.
- Single push: unit 1 pushes prd=5, tag=3, data=0xDEAD at cycle 0. The CDB shows valid, prd 5, tag 3, data 0xDEAD, src 1 in cycle 2 only.
- Round-robin fairness: all 3 units push every cycle while ready. Grants rotate 0,1,2,0,… with no unit starved. o_req_ready[k] drops once its FIFO holds 2 entries.
- Flush:
  - Setup: units hold tags 2, 6 and 9, with i_rob_head = 0.
  - Stimulus: mispredict with tag 5.
  - Required response: tags 6 and 9 are never broadcast, and tag 2 is broadcast.
  - Concurrent push: a push of tag 7 in the mispredict cycle is dropped.
- Wrap-around, with CDB_AGE_PRIORITY_EN, i_rob_head = 14: tag 15 and tag 1 are ready simultaneously, and tag 15 wins first.
- Reset mid-stream: assert reset while both FIFOs are full. No broadcast occurs after reset, and o_req_ready returns to all 1.
